// File: rtl/e_mdu_if.sv
// Multiply/divide unit bus: pipeline-side controls and operands in, HI/LO state and md result out.
interface e_mdu_if;
    logic        Req;
    logic        Start;
    logic [3:0]  MDop;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] md_out;

    modport master (output Req, Start, MDop, A, B,
                    input  Busy, HI, LO, md_out);
    modport slave  (input  Req, Start, MDop, A, B,
                    output Busy, HI, LO, md_out);
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/multu/div/divu with HI/LO registers and mthi/mtlo.
// state  | meaning
// S_IDLE | no arithmetic op in flight; accepts new op or mthi/mtlo
// S_BUSY | op latched; counter runs down, HI/LO commit when it reaches 1
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic   clk,
    input  logic   reset,
    e_mdu_if.slave md
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t         state;
    logic [3:0]     op_q;
    logic [31:0]    a_q;
    logic [31:0]    b_q;
    logic [CW-1:0]  cnt;
    logic [31:0]    hi_q;
    logic [31:0]    lo_q;
    logic           busy_q;

    logic [63:0]    prod_s;
    logic [63:0]    prod_u;
    logic           div_signed;
    logic [31:0]    mag_a;
    logic [31:0]    mag_b;
    logic [31:0]    divisor;
    logic [31:0]    quo;
    logic [31:0]    rem;
    logic [31:0]    q_res;
    logic [31:0]    r_res;
    logic           is_arith;

    assign is_arith = (md.MDop >= 4'd1) && (md.MDop <= 4'd4);

    // Signed divide via magnitudes: quotient truncates toward zero and the remainder
    // takes the dividend's sign; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u     = {32'd0, a_q} * {32'd0, b_q};
        div_signed = (op_q == 4'd3);
        mag_a      = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
        mag_b      = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
        divisor    = (b_q == 32'd0) ? 32'd1 : mag_b;
        quo        = mag_a / divisor;
        rem        = mag_a % divisor;
        q_res      = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - quo) : quo;
        r_res      = (div_signed && a_q[31]) ? (32'd0 - rem) : rem;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            op_q   <= 4'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            cnt    <= '0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!md.Req) begin
                        if (md.Start && is_arith) begin
                            op_q   <= md.MDop;
                            a_q    <= md.A;
                            b_q    <= md.B;
                            cnt    <= (md.MDop <= 4'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                            busy_q <= 1'b1;
                            state  <= S_BUSY;
                        end else if (md.MDop == 4'd5) begin
                            hi_q <= md.A;
                        end else if (md.MDop == 4'd6) begin
                            lo_q <= md.A;
                        end
                    end
                end
                S_BUSY: begin
                    // Req does not affect an op already in flight: it belongs to an older instruction.
                    if (cnt == CW'(1)) begin
                        case (op_q)
                            4'd1: {hi_q, lo_q} <= prod_s;
                            4'd2: {hi_q, lo_q} <= prod_u;
                            4'd3, 4'd4: begin
                                if (b_q != 32'd0) begin
                                    lo_q <= q_res;
                                    hi_q <= r_res;
                                end
                            end
                            default: ;
                        endcase
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign md.Busy   = busy_q;
    assign md.HI     = hi_q;
    assign md.LO     = lo_q;
    assign md.md_out = (md.MDop == 4'd7) ? hi_q :
                       (md.MDop == 4'd8) ? lo_q : 32'd0;
endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: directed ops push expected HI/LO and busy length; a monitor checks each completion.
module tb_e_mdu;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    e_mdu_if bus();

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.Busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, {31'd0, bus.Busy}, 32'd0);
    endtask

    task automatic start_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                            input int cyc, input bit push);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.MDop  = op;
        bus.A     = a;
        bus.B     = b;
        if (push) exp_q.push_back(exp_t'{hi, lo, cyc, nm});
        @(negedge clk);
        bus.Start = 1'b0;
        bus.MDop  = 4'd0;
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] a, input logic req);
        @(negedge clk);
        bus.MDop = op;
        bus.A    = a;
        bus.Req  = req;
        @(negedge clk);
        bus.MDop = 4'd0;
        bus.Req  = 1'b0;
    endtask

    task automatic chk_md(input string name, input logic [3:0] op, input logic [31:0] exp);
        bus.MDop = op;
        #1;
        chk(name, bus.md_out, exp);
        bus.MDop = 4'd0;
    endtask

    // Completion monitor: a falling Busy means an op committed; compare against the oldest expectation.
    initial begin
        bit   prev;
        int   bc;
        exp_t e;
        prev = 1'b0;
        bc   = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev = 1'b0;
                bc   = 0;
            end else begin
                if (bus.Busy) begin
                    bc++;
                end else if (prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got completion after %0d busy cycles, expected none", bc);
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.name, "_hi"}, bus.HI, e.hi);
                        chk({e.name, "_lo"}, bus.LO, e.lo);
                        chk({e.name, "_cycles"}, 32'(bc), 32'(e.cycles));
                    end
                    bc = 0;
                end
                prev = bus.Busy;
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        bus.Req   = 1'b0;
        bus.Start = 1'b0;
        bus.MDop  = 4'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        chk_md("rst_md_hi", 4'd7, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        start_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1);
        wait_idle("mult");
        start_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 1);
        wait_idle("multu");
        start_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1);
        wait_idle("div_neg");

        move_to(4'd5, 32'd5, 1'b0);
        move_to(4'd6, 32'd9, 1'b0);
        chk("mthi5", bus.HI, 32'd5);
        chk("mtlo9", bus.LO, 32'd9);
        start_op("divu_zero", 4'd4, 32'd7, 32'd0, 32'd5, 32'd9, 10, 1);
        wait_idle("divu_zero");

        start_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1);
        wait_idle("div_ovf");

        move_to(4'd5, 32'h1234, 1'b1);
        chk("mthi_req", bus.HI, 32'd0);
        move_to(4'd5, 32'h1234, 1'b0);
        chk("mthi_ok", bus.HI, 32'h1234);
        chk_md("md_hi", 4'd7, 32'h1234);
        chk_md("md_lo", 4'd8, 32'h8000_0000);
        chk_md("md_none", 4'd0, 32'd0);
        chk_md("md_bad", 4'd9, 32'd0);

        // div 100/7 with an ignored mult, operand changes, blocked mthi and a Req pulse while busy
        @(negedge clk);
        bus.Start = 1'b1;
        bus.MDop  = 4'd3;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        exp_q.push_back(exp_t'{32'd2, 32'd14, 10, "div_busy"});
        @(negedge clk);
        bus.MDop  = 4'd1;
        bus.A     = 32'd3;
        bus.B     = 32'd3;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        chk_md("md_preop", 4'd8, 32'h8000_0000);
        @(negedge clk);
        bus.MDop  = 4'd5;
        bus.A     = 32'hDEAD;
        @(negedge clk);
        bus.MDop  = 4'd0;
        bus.Req   = 1'b1;
        chk("mthi_busy", bus.HI, 32'h1234);
        @(negedge clk);
        bus.Req   = 1'b0;
        wait_idle("div_busy");
        chk_md("md_rem", 4'd7, 32'd2);

        start_op("div_negb", 4'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, 1);
        wait_idle("div_negb");

        @(negedge clk);
        bus.Req   = 1'b1;
        bus.Start = 1'b1;
        bus.MDop  = 4'd1;
        bus.A     = 32'd2;
        bus.B     = 32'd2;
        @(negedge clk);
        bus.Req   = 1'b0;
        bus.Start = 1'b0;
        bus.MDop  = 4'd0;
        chk("req_blocks_start", {31'd0, bus.Busy}, 32'd0);
        chk("req_hi_kept", bus.HI, 32'd1);

        start_op("mult_abort", 4'd1, 32'd5, 32'd5, 32'd0, 32'd0, 5, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.Busy}, 32'd0);
        chk("abort_hi", bus.HI, 32'd0);
        chk("abort_lo", bus.LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        start_op("mult_after", 4'd1, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1);
        wait_idle("mult_after");

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
